// File: rtl/sdf_butterfly_stage.sv
// rtl/sdf_butterfly_stage.sv - radix-2 DIF single-path delay-feedback butterfly stage
//
// Purpose: one SDF FFT stage. The first half of each frame is parked in an
// external DEPTH-deep delay FIFO. During the second half each stored sample is
// paired with the arriving one: the halved sum is emitted directly and the
// halved difference is sent back into the FIFO. The differences are emitted
// DEPTH clocks later, tagged with their twiddle index, overlapped with the
// next frame's first half or with a drain phase.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_real, in_img     input sample stream (2*DEPTH back-to-back per frame)
//   fifo_out_real, fifo_out_img   tap from the external delay FIFO
//   fifo_in_real, fifo_in_img     data into the external delay FIFO (combinational)
//   out_valid, out_real, out_img  registered butterfly result
//   out_is_diff                   1 = difference term awaiting a twiddle multiply
//   tw_addr                       twiddle index for difference terms, 0 for sums
//   err                           sticky framing-error flag

module sdf_butterfly_stage #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 32,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_real,
    input  logic [WIDTH-1:0]      in_img,
    input  logic [WIDTH-1:0]      fifo_out_real,
    input  logic [WIDTH-1:0]      fifo_out_img,
    output logic [WIDTH-1:0]      fifo_in_real,
    output logic [WIDTH-1:0]      fifo_in_img,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_real,
    output logic [WIDTH-1:0]      out_img,
    output logic                  out_is_diff,
    output logic [LOG2_DEPTH-1:0] tw_addr,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMBINE,
        DRAIN
    } state_t;

    localparam logic [LOG2_DEPTH-1:0] LAST = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [LOG2_DEPTH-1:0] ONE  = LOG2_DEPTH'(1);

    state_t                  state, stateNext;
    logic [LOG2_DEPTH-1:0]   cnt, cntNext;
    logic                    pending, pendingNext;
    logic                    errNext;
    logic                    validNext;
    logic                    isDiffNext;
    logic [WIDTH-1:0]        realNext, imgNext;
    logic [LOG2_DEPTH-1:0]   twNext;
    logic                    emitDiff;

    // Butterfly at WIDTH+1 bits; dropping bit 0 is an arithmetic shift right
    // by one (floor), so the result always fits back into WIDTH bits.
    logic [WIDTH:0] sumReal, sumImg, diffReal, diffImg;

    assign sumReal  = {fifo_out_real[WIDTH-1], fifo_out_real} + {in_real[WIDTH-1], in_real};
    assign sumImg   = {fifo_out_img[WIDTH-1],  fifo_out_img}  + {in_img[WIDTH-1],  in_img};
    assign diffReal = {fifo_out_real[WIDTH-1], fifo_out_real} - {in_real[WIDTH-1], in_real};
    assign diffImg  = {fifo_out_img[WIDTH-1],  fifo_out_img}  - {in_img[WIDTH-1],  in_img};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= 1'b0;
            err         <= 1'b0;
            out_valid   <= 1'b0;
            out_real    <= '0;
            out_img     <= '0;
            out_is_diff <= 1'b0;
            tw_addr     <= '0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            pending     <= pendingNext;
            err         <= errNext;
            out_valid   <= validNext;
            out_real    <= realNext;
            out_img     <= imgNext;
            out_is_diff <= isDiffNext;
            tw_addr     <= twNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        pendingNext  = pending;
        errNext      = err;
        validNext    = 1'b0;
        isDiffNext   = out_is_diff;
        realNext     = out_real;
        imgNext      = out_img;
        twNext       = tw_addr;
        emitDiff     = 1'b0;
        fifo_in_real = '0;
        fifo_in_img  = '0;

        case (state)
            IDLE: begin
                // The starting sample is k=0 and must enter the FIFO this
                // very cycle, so LOAD continues from index 1.
                if (in_valid) begin
                    fifo_in_real = in_real;
                    fifo_in_img  = in_img;
                    stateNext    = LOAD;
                    cntNext      = ONE;
                end
            end

            LOAD: begin
                if (in_valid) begin
                    fifo_in_real = in_real;
                    fifo_in_img  = in_img;
                    emitDiff     = pending;
                    if (cnt == LAST) begin
                        stateNext = COMBINE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + ONE;
                    end
                end else if (pending && cnt == '0) begin
                    // Frame boundary with no follow-on frame: this cycle is
                    // the first drain cycle.
                    emitDiff  = 1'b1;
                    stateNext = DRAIN;
                    cntNext   = ONE;
                end else begin
                    errNext     = 1'b1;
                    pendingNext = 1'b0;
                    stateNext   = IDLE;
                    cntNext     = '0;
                end
            end

            COMBINE: begin
                if (in_valid) begin
                    fifo_in_real = diffReal[WIDTH:1];
                    fifo_in_img  = diffImg[WIDTH:1];
                    validNext    = 1'b1;
                    isDiffNext   = 1'b0;
                    realNext     = sumReal[WIDTH:1];
                    imgNext      = sumImg[WIDTH:1];
                    twNext       = '0;
                    if (cnt == LAST) begin
                        // Whether a new frame follows is decided next cycle
                        // in LOAD at cnt=0.
                        stateNext   = LOAD;
                        cntNext     = '0;
                        pendingNext = 1'b1;
                    end else begin
                        cntNext = cnt + ONE;
                    end
                end else begin
                    errNext     = 1'b1;
                    pendingNext = 1'b0;
                    stateNext   = IDLE;
                    cntNext     = '0;
                end
            end

            DRAIN: begin
                // Input during drain is dropped; the FIFO is fed zeros.
                emitDiff = pending;
                if (in_valid) begin
                    errNext = 1'b1;
                end
                if (cnt == LAST) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + ONE;
                end
            end

            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase

        // Difference terms come straight from the FIFO tap, DEPTH clocks after
        // they were written during COMBINE.
        if (emitDiff) begin
            validNext  = 1'b1;
            isDiffNext = 1'b1;
            realNext   = fifo_out_real;
            imgNext    = fifo_out_img;
            twNext     = cnt;
            if (cnt == LAST) begin
                pendingNext = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// tb/tb_sdf_butterfly_stage.sv - directed self-checking bench for sdf_butterfly_stage

module tb_sdf_butterfly_stage;

    localparam int W = 16;
    localparam int D = 4;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_real, in_img;
    logic [W-1:0] fifo_out_real, fifo_out_img;
    logic [W-1:0] fifo_in_real, fifo_in_img;
    logic         out_valid;
    logic [W-1:0] out_real, out_img;
    logic         out_is_diff;
    logic [L-1:0] tw_addr;
    logic         err;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] fifoR, fifoI;

    // Frame stimulus and hand-computed results: 0 = ramp, 1 = mixed signs, 2 = extremes
    logic [W-1:0] fR [3][8];
    logic [W-1:0] fI [3][8];
    logic [W-1:0] sR [3][4];
    logic [W-1:0] sI [3][4];
    logic [W-1:0] dfR[3][4];
    logic [W-1:0] dfI[3][4];

    // External delay FIFO: DEPTH clocks, shifts every clock, no reset.
    logic [W-1:0] dR[D];
    logic [W-1:0] dI[D];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dR[0] <= fifo_in_real;
        dI[0] <= fifo_in_img;
        for (int k = 1; k < D; k++) begin
            dR[k] <= dR[k-1];
            dI[k] <= dI[k-1];
        end
    end

    assign fifo_out_real = dR[D-1];
    assign fifo_out_img  = dI[D-1];

    sdf_butterfly_stage #(
        .WIDTH(W),
        .DEPTH(D),
        .LOG2_DEPTH(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_real(in_real),
        .in_img(in_img),
        .fifo_out_real(fifo_out_real),
        .fifo_out_img(fifo_out_img),
        .fifo_in_real(fifo_in_real),
        .fifo_in_img(fifo_in_img),
        .out_valid(out_valid),
        .out_real(out_real),
        .out_img(out_img),
        .out_is_diff(out_is_diff),
        .tw_addr(tw_addr),
        .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, capture fifo_in mid-cycle, then step past the edge.
    task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
        in_valid = v;
        in_real  = r;
        in_img   = i;
        #1;
        fifoR = fifo_in_real;
        fifoI = fifo_in_img;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [W-1:0] r,
                             input logic [W-1:0] i, input logic d, input logic [L-1:0] tw);
        chk({tag, " valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            chk({tag, " data"}, 64'({out_is_diff, tw_addr, out_real, out_img}), 64'({d, tw, r, i}));
        end
    endtask

    task automatic chkFifo(input string tag, input logic [W-1:0] r, input logic [W-1:0] i);
        chk({tag, " fifo_in"}, 64'({fifoR, fifoI}), 64'({r, i}));
    endtask

    // Feed sample k of frame f and check what went into the delay FIFO.
    task automatic sample(input string tag, input int f, input int k);
        step(1'b1, fR[f][k], fI[f][k]);
        if (k < D) chkFifo($sformatf("%s k%0d", tag, k), fR[f][k], fI[f][k]);
        else       chkFifo($sformatf("%s k%0d", tag, k), dfR[f][k-D], dfI[f][k-D]);
    endtask

    task automatic expSum(input string tag, input int f, input int j);
        expectOut($sformatf("%s sum%0d", tag, j), 1'b1, sR[f][j], sI[f][j], 1'b0, '0);
    endtask

    task automatic expDiff(input string tag, input int f, input int j);
        expectOut($sformatf("%s diff%0d", tag, j), 1'b1, dfR[f][j], dfI[f][j], 1'b1, L'(j));
    endtask

    task automatic expNone(input string tag);
        expectOut(tag, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Whole frame f with drain, checked cycle by cycle.
    task automatic fullFrame(input string tag, input int f);
        for (int k = 0; k < D; k++) begin
            sample(tag, f, k);
            expNone($sformatf("%s load%0d", tag, k));
        end
        for (int k = D; k < 2*D; k++) begin
            sample(tag, f, k);
            expSum(tag, f, k-D);
        end
        for (int j = 0; j < D; j++) begin
            step(1'b0, '0, '0);
            chkFifo($sformatf("%s drain%0d", tag, j), '0, '0);
            expDiff(tag, f, j);
        end
        step(1'b0, '0, '0);
        expNone({tag, " idle"});
    endtask

    initial begin
        fR[0] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd10, 16'd20, 16'd30, 16'd40};
        fI[0] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        sR[0] = '{16'd55, 16'd110, 16'd165, 16'd220};
        sI[0] = '{16'd0, 16'd0, 16'd0, 16'd0};
        dfR[0] = '{16'd45, 16'd90, 16'd135, 16'd180};
        dfI[0] = '{16'd0, 16'd0, 16'd0, 16'd0};

        fR[1] = '{16'd8, 16'd6, 16'hFFFC, 16'hFFFD, 16'd2, 16'd2, 16'd2, 16'd2};
        fI[1] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd3, 16'd3, 16'd3};
        sR[1] = '{16'd5, 16'd4, 16'hFFFF, 16'hFFFF};
        sI[1] = '{16'd2, 16'd2, 16'd3, 16'd3};
        dfR[1] = '{16'd3, 16'd2, 16'hFFFD, 16'hFFFD};
        dfI[1] = '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0};

        fR[2] = '{16'h7FFF, 16'h8000, 16'd0, 16'd0, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0};
        fI[2] = '{16'h8000, 16'h7FFF, 16'd0, 16'd0, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0};
        sR[2] = '{16'h7FFF, 16'hFFFF, 16'd0, 16'd0};
        sI[2] = '{16'hFFFF, 16'h7FFF, 16'd0, 16'd0};
        dfR[2] = '{16'd0, 16'h8000, 16'd0, 16'd0};
        dfI[2] = '{16'h8000, 16'd0, 16'd0, 16'd0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_real  = '0;
        in_img   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 64'({out_valid, out_is_diff, tw_addr, out_real, out_img}), 64'(0));
        chk("reset err", 64'(err), 64'(0));
        chk("reset fifo_in", 64'({fifo_in_real, fifo_in_img}), 64'(0));
        rst_n = 1'b1;
        step(1'b0, '0, '0);
        expNone("post reset idle");

        // Single frame
        fullFrame("single", 0);
        chk("single err", 64'(err), 64'(0));

        // Two back-to-back frames: gapless output for 16 cycles
        for (int k = 0; k < D; k++) begin
            sample("b2b f0", 0, k);
            expNone($sformatf("b2b load%0d", k));
        end
        for (int k = D; k < 2*D; k++) begin
            sample("b2b f0", 0, k);
            expSum("b2b f0", 0, k-D);
        end
        for (int k = 0; k < D; k++) begin
            sample("b2b f1", 1, k);
            expDiff("b2b f0", 0, k);
        end
        for (int k = D; k < 2*D; k++) begin
            sample("b2b f1", 1, k);
            expSum("b2b f1", 1, k-D);
        end
        for (int j = 0; j < D; j++) begin
            step(1'b0, '0, '0);
            expDiff("b2b f1", 1, j);
        end
        step(1'b0, '0, '0);
        expNone("b2b idle");
        chk("b2b err", 64'(err), 64'(0));

        // in_valid pulse during drain
        for (int k = 0; k < D; k++) begin
            sample("drainpulse", 0, k);
            expNone($sformatf("drainpulse load%0d", k));
        end
        for (int k = D; k < 2*D; k++) begin
            sample("drainpulse", 0, k);
            expSum("drainpulse", 0, k-D);
        end
        step(1'b0, '0, '0);
        expDiff("drainpulse", 0, 0);
        chk("drainpulse err before", 64'(err), 64'(0));
        step(1'b1, 16'd999, 16'd999);
        chkFifo("drainpulse dropped", '0, '0);
        expDiff("drainpulse", 0, 1);
        chk("drainpulse err after", 64'(err), 64'(1));
        step(1'b0, '0, '0);
        expDiff("drainpulse", 0, 2);
        step(1'b0, '0, '0);
        expDiff("drainpulse", 0, 3);
        step(1'b0, '0, '0);
        expNone("drainpulse idle");

        // Reset in the middle of a frame
        for (int k = 0; k < D; k++) begin
            sample("midreset", 0, k);
            expNone($sformatf("midreset load%0d", k));
        end
        sample("midreset", 0, 4);
        expSum("midreset", 0, 0);
        sample("midreset", 0, 5);
        expSum("midreset", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", 64'({out_valid, out_is_diff, tw_addr, out_real, out_img}), 64'(0));
        chk("midreset err", 64'(err), 64'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 2*D; j++) begin
            step(1'b0, '0, '0);
            expNone($sformatf("midreset stale%0d", j));
        end

        // in_valid dropped at k=5
        for (int k = 0; k < D; k++) begin
            sample("drop", 0, k);
            expNone($sformatf("drop load%0d", k));
        end
        sample("drop", 0, 4);
        expSum("drop", 0, 0);
        chk("drop err before", 64'(err), 64'(0));
        step(1'b0, '0, '0);
        expNone("drop k5");
        chk("drop err after", 64'(err), 64'(1));
        step(1'b0, '0, '0);
        expNone("drop idle");
        chkFifo("drop idle", '0, '0);

        // Clean extreme-value frame while err stays set
        fullFrame("extremes", 2);
        chk("extremes err sticky", 64'(err), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
